// File: rtl/multiexp_feeder_if.sv
// AXI-style stream bundle shared by the load side and the multiexp core side.
interface if_axi_stream #(
  parameter int unsigned DAT_BYTS = 128,
  parameter int unsigned CTL_BITS = 8,
  parameter int unsigned MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1
);
  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [DAT_BYTS*8-1:0] dat;
  logic [CTL_BITS-1:0]   ctl;
  logic [MOD_BITS-1:0]   mod;

  modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/multiexp_feeder.sv
// Buffers NUM_IN (point, scalar) pairs and replays the set NUM_PASSES times
// onto the multiexp core's point/scalar stream, one pair per beat.
module multiexp_feeder #(
  parameter int unsigned FP_BITS    = 768,
  parameter int unsigned FE_BITS    = 256,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned NUM_PASSES = 256,
  parameter int unsigned CTL_BITS   = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  if_axi_stream.slave                         i_load_if,
  if_axi_stream.master                        o_pnt_scl_if,
  output logic                                o_busy,
  output logic [$clog2(NUM_PASSES+1)-1:0]     o_pass,
  output logic                                o_done
);

  localparam int unsigned PAIR_W = FP_BITS + FE_BITS;
  localparam int unsigned DAT_W  = ((PAIR_W + 7) / 8) * 8;
  localparam int unsigned IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned PASS_W = $clog2(NUM_PASSES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_IN - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  typedef enum logic {LOAD, SEND} state_t;

  state_t              state;
  logic [PAIR_W-1:0]   mem [NUM_IN];
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [PASS_W-1:0]   pass_cnt;
  logic                all_loaded;   // final beat already placed in the output register
  logic                load_hs;
  logic                beat_ld;
  logic                beat_hs;

  assign load_hs = (state == LOAD) && i_load_if.val && i_load_if.rdy;
  assign beat_ld = (state == SEND) && !all_loaded && (!o_pnt_scl_if.val || o_pnt_scl_if.rdy);
  assign beat_hs = o_pnt_scl_if.val && o_pnt_scl_if.rdy;

  // Pair storage; contents need no reset since a full batch is always loaded first.
  always_ff @(posedge i_clk) begin
    if (load_hs) mem[wr_idx] <= i_load_if.dat[PAIR_W-1:0];
  end

  // Load/replay control with registered stream and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= LOAD;
      wr_idx             <= '0;
      rd_idx             <= '0;
      pass_cnt           <= '0;
      all_loaded         <= 1'b0;
      i_load_if.rdy      <= 1'b0;
      o_pnt_scl_if.val   <= 1'b0;
      o_pnt_scl_if.dat   <= '0;
      o_pnt_scl_if.ctl   <= '0;
      o_pnt_scl_if.sop   <= 1'b0;
      o_pnt_scl_if.eop   <= 1'b0;
      o_pnt_scl_if.mod   <= '0;
      o_pnt_scl_if.err   <= 1'b0;
      o_busy             <= 1'b0;
      o_pass             <= '0;
      o_done             <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        LOAD: begin
          i_load_if.rdy <= 1'b1;
          o_busy        <= 1'b0;
          if (load_hs) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx        <= '0;
              rd_idx        <= '0;
              pass_cnt      <= '0;
              o_pass        <= '0;
              all_loaded    <= 1'b0;
              i_load_if.rdy <= 1'b0;
              o_busy        <= 1'b1;
              state         <= SEND;
            end else begin
              wr_idx <= wr_idx + IDX_W'(1);
            end
          end
        end
        SEND: begin
          if (beat_ld) begin
            o_pnt_scl_if.val <= 1'b1;
            o_pnt_scl_if.dat <= DAT_W'(mem[rd_idx]);
            o_pnt_scl_if.ctl <= CTL_BITS'(rd_idx);
            o_pnt_scl_if.sop <= 1'b1;
            o_pnt_scl_if.eop <= 1'b1;
            o_pnt_scl_if.mod <= '0;
            o_pnt_scl_if.err <= 1'b0;
            o_pass           <= pass_cnt;
            if (rd_idx == LAST_IDX) begin
              rd_idx   <= '0;
              pass_cnt <= pass_cnt + PASS_W'(1);
              if (pass_cnt == LAST_PASS) all_loaded <= 1'b1;
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
            end
          end else if (beat_hs) begin
            o_pnt_scl_if.val <= 1'b0;
            if (all_loaded) begin
              o_done        <= 1'b1;
              o_busy        <= 1'b0;
              i_load_if.rdy <= 1'b1;
              state         <= LOAD;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
